// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: sequencer states and requester identifiers.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_A = 1'b0;
  localparam port_id_t PORT_B = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, clear-control and RAM command bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
);
  logic          clr_start;
  logic          clr_busy;
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output clr_start, a_req, a_we, a_addr, a_wdata, b_req, b_addr,
    input  clr_busy, a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
  );

  modport slave (
    input  clr_start, a_req, a_we, a_addr, a_wdata, b_req, b_addr, ram_rdata,
    output clr_busy, a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
           ram_we, ram_addr, ram_wdata
  );

  modport ram (
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; index 0 is port A, index 1 is port B.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  port_id_t r_last;

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (i_req[0] && i_req[1]) begin
        o_gnt = (r_last == PORT_A) ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  // Priority pointer only moves when a grant is actually issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= PORT_B;
    end else if (o_gnt[0]) begin
      r_last <= PORT_A;
    end else if (o_gnt[1]) begin
      r_last <= PORT_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between an edit port (A) and a read-only
// scanner port (B), with a built-in full-memory clear sweep.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  state_t        r_state;
  logic [AW-1:0] r_clr_cnt;
  logic          r_clr_busy;
  logic          r_rd_v;
  port_id_t      r_rd_own;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_rdata;

  logic          w_arb_en;
  logic [1:0]    w_gnt;

  // A clear request wins the cycle it arrives, so arbitration is held off.
  assign w_arb_en = !reset && (r_state == ARB) && !bus.clr_start;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_arb_en),
    .i_req ({bus.b_req, bus.a_req}),
    .o_gnt (w_gnt)
  );

  assign bus.a_gnt    = w_gnt[0];
  assign bus.b_gnt    = w_gnt[1];
  assign bus.clr_busy = r_clr_busy;
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.rdata    = r_rdata;

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (!reset) begin
      if (r_state == CLEAR) begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = r_clr_cnt;
      end else if (w_gnt[0]) begin
        bus.ram_we    = bus.a_we;
        bus.ram_addr  = bus.a_addr;
        bus.ram_wdata = bus.a_wdata;
      end else if (w_gnt[1]) begin
        bus.ram_addr = bus.b_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ARB;
      r_clr_busy <= 1'b0;
      r_clr_cnt  <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (bus.clr_start) begin
            r_state    <= CLEAR;
            r_clr_busy <= 1'b1;
            r_clr_cnt  <= '0;
          end
        end
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) begin
            r_state    <= ARB;
            r_clr_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= ARB;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Grant cycle tags the read; RAM data is captured one cycle later and the
  // owner's rvalid is raised alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_v     <= 1'b0;
      r_rd_own   <= PORT_A;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_v     <= (w_gnt[0] && !bus.a_we) || w_gnt[1];
      r_rd_own   <= w_gnt[0] ? PORT_A : PORT_B;
      r_a_rvalid <= r_rd_v && (r_rd_own == PORT_A);
      r_b_rvalid <= r_rd_v && (r_rd_own == PORT_B);
      if (r_rd_v) begin
        r_rdata <= bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [3:0] mem [16];

  mem_port_arbiter_if #(.AW(4), .DW(4)) bus_if ();

  mem_port_arbiter #(.AW(4), .DW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
    bus_if.ram_rdata <= mem[bus_if.ram_addr];
  end

  task automatic idle_inputs();
    bus_if.clr_start = 1'b0;
    bus_if.a_req     = 1'b0;
    bus_if.a_we      = 1'b0;
    bus_if.a_addr    = '0;
    bus_if.a_wdata   = '0;
    bus_if.b_req     = 1'b0;
    bus_if.b_addr    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_all();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus_if.a_req   = 1'b1;
      bus_if.a_we    = 1'b1;
      bus_if.a_addr  = 4'(i);
      bus_if.a_wdata = 4'((i % 15) + 1);
    end
    @(negedge clk);
    bus_if.a_req = 1'b0;
    bus_if.a_we  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_if.a_req = 1'b1; bus_if.a_we = 1'b1; bus_if.a_addr = 4'h7; bus_if.a_wdata = 4'h5;
    bus_if.b_req = 1'b1; bus_if.b_addr = 4'h2;
    #1;
    checks++; if (bus_if.a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt got %b expected 0", bus_if.a_gnt); end
    checks++; if (bus_if.b_gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt got %b expected 0", bus_if.b_gnt); end
    checks++; if (bus_if.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b expected 0", bus_if.ram_we); end
    checks++; if (bus_if.ram_addr !== 4'h0) begin errors++; $display("FAIL rst_ram_addr got %h expected 0", bus_if.ram_addr); end
    checks++; if (bus_if.ram_wdata !== 4'h0) begin errors++; $display("FAIL rst_ram_wdata got %h expected 0", bus_if.ram_wdata); end
    @(negedge clk);
    #1;
    checks++; if (bus_if.clr_busy !== 1'b0) begin errors++; $display("FAIL rst_clr_busy got %b expected 0", bus_if.clr_busy); end
    checks++; if (bus_if.a_rvalid !== 1'b0 || bus_if.b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b expected 00", bus_if.a_rvalid, bus_if.b_rvalid); end
    checks++; if (bus_if.rdata !== 4'h0) begin errors++; $display("FAIL rst_rdata got %h expected 0", bus_if.rdata); end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clk);
    bus_if.a_req = 1'b1; bus_if.a_we = 1'b1; bus_if.a_addr = 4'h3; bus_if.a_wdata = 4'hA;
    #1;
    checks++; if (bus_if.a_gnt !== 1'b1) begin errors++; $display("FAIL wr_a_gnt got %b expected 1", bus_if.a_gnt); end
    checks++; if (bus_if.ram_we !== 1'b1) begin errors++; $display("FAIL wr_ram_we got %b expected 1", bus_if.ram_we); end
    checks++; if (bus_if.ram_addr !== 4'h3) begin errors++; $display("FAIL wr_ram_addr got %h expected 3", bus_if.ram_addr); end
    checks++; if (bus_if.ram_wdata !== 4'hA) begin errors++; $display("FAIL wr_ram_wdata got %h expected a", bus_if.ram_wdata); end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus_if.a_rvalid !== 1'b0 || bus_if.b_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid[%0d] got %b%b expected 00", i, bus_if.a_rvalid, bus_if.b_rvalid); end
      @(negedge clk);
    end
  endtask

  task automatic test_read();
    bus_if.a_req = 1'b1; bus_if.a_we = 1'b0; bus_if.a_addr = 4'h3;
    #1;
    checks++; if (bus_if.a_gnt !== 1'b1 || bus_if.ram_we !== 1'b0) begin errors++; $display("FAIL rd_grant got gnt=%b we=%b expected gnt=1 we=0", bus_if.a_gnt, bus_if.ram_we); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus_if.a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_n1_rvalid got %b expected 0", bus_if.a_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (bus_if.a_rvalid !== 1'b1) begin errors++; $display("FAIL rd_n2_a_rvalid got %b expected 1", bus_if.a_rvalid); end
    checks++; if (bus_if.b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_n2_b_rvalid got %b expected 0", bus_if.b_rvalid); end
    checks++; if (bus_if.rdata !== 4'hA) begin errors++; $display("FAIL rd_n2_rdata got %h expected a", bus_if.rdata); end
    @(negedge clk);
    #1;
    checks++; if (bus_if.a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_n3_rvalid got %b expected 0", bus_if.a_rvalid); end
    checks++; if (bus_if.rdata !== 4'hA) begin errors++; $display("FAIL rd_n3_rdata_hold got %h expected a", bus_if.rdata); end
  endtask

  task automatic test_back_to_back();
    logic exp_a;
    do_reset();
    @(negedge clk);
    bus_if.a_req = 1'b1; bus_if.a_we = 1'b0; bus_if.a_addr = 4'h3;
    bus_if.b_req = 1'b1; bus_if.b_addr = 4'h3;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_a = (i % 2) == 0;
      checks++; if (bus_if.a_gnt !== exp_a || bus_if.b_gnt !== !exp_a) begin errors++; $display("FAIL rr_gnt[%0d] got a=%b b=%b expected a=%b b=%b", i, bus_if.a_gnt, bus_if.b_gnt, exp_a, !exp_a); end
      if (i >= 2) begin
        checks++; if (bus_if.a_rvalid !== exp_a || bus_if.b_rvalid !== !exp_a) begin errors++; $display("FAIL rr_rvalid[%0d] got a=%b b=%b expected a=%b b=%b", i, bus_if.a_rvalid, bus_if.b_rvalid, exp_a, !exp_a); end
        checks++; if (bus_if.rdata !== 4'hA) begin errors++; $display("FAIL rr_rdata[%0d] got %h expected a", i, bus_if.rdata); end
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_clear();
    write_all();
    bus_if.clr_start = 1'b1;
    bus_if.b_req = 1'b1; bus_if.b_addr = 4'h5;
    #1;
    checks++; if (bus_if.b_gnt !== 1'b0 || bus_if.ram_we !== 1'b0) begin errors++; $display("FAIL clr_entry got gnt=%b we=%b expected gnt=0 we=0", bus_if.b_gnt, bus_if.ram_we); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus_if.clr_start = 1'b0;
      #1;
      checks++;
      if (bus_if.clr_busy !== 1'b1 || bus_if.ram_we !== 1'b1 || bus_if.ram_addr !== 4'(k) ||
          bus_if.ram_wdata !== 4'h0 || bus_if.b_gnt !== 1'b0) begin
        errors++;
        $display("FAIL clr_sweep[%0d] got busy=%b we=%b addr=%h wd=%h bgnt=%b expected busy=1 we=1 addr=%h wd=0 bgnt=0",
                 k, bus_if.clr_busy, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_wdata, bus_if.b_gnt, 4'(k));
      end
    end
    @(negedge clk);
    #1;
    checks++; if (bus_if.clr_busy !== 1'b0 || bus_if.b_gnt !== 1'b1 || bus_if.ram_addr !== 4'h5) begin errors++; $display("FAIL clr_exit got busy=%b bgnt=%b addr=%h expected busy=0 bgnt=1 addr=5", bus_if.clr_busy, bus_if.b_gnt, bus_if.ram_addr); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    checks++; if (bus_if.b_rvalid !== 1'b1 || bus_if.rdata !== 4'h0) begin errors++; $display("FAIL clr_readback got rvalid=%b rdata=%h expected rvalid=1 rdata=0", bus_if.b_rvalid, bus_if.rdata); end
  endtask

  task automatic test_clear_restart_ignored();
    int busy;
    write_all();
    bus_if.clr_start = 1'b1;
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus_if.clr_start = (busy == 5);
      #1;
      if (bus_if.clr_busy) busy++;
      else if (busy > 0) break;
    end
    bus_if.clr_start = 1'b0;
    checks++; if (busy !== 16) begin errors++; $display("FAIL clr_busy_len got %0d expected 16", busy); end
  endtask

  task automatic test_clear_reset_abort();
    write_all();
    bus_if.clr_start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      bus_if.clr_start = 1'b0;
      if (k == 8) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus_if.clr_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", bus_if.clr_busy); end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (mem[j] !== ((j < 8) ? 4'h0 : 4'((j % 15) + 1))) begin
        errors++;
        $display("FAIL abort_mem[%0d] got %h expected %h", j, mem[j], (j < 8) ? 4'h0 : 4'((j % 15) + 1));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus_if.a_req = 1'b1; bus_if.a_we = 1'b0; bus_if.a_addr = 4'h9;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    checks++; if (bus_if.a_rvalid !== 1'b1 || bus_if.rdata !== 4'hA) begin errors++; $display("FAIL pre_read got rvalid=%b rdata=%h expected rvalid=1 rdata=a", bus_if.a_rvalid, bus_if.rdata); end
    @(negedge clk);
    bus_if.a_req = 1'b1; bus_if.a_we = 1'b0; bus_if.a_addr = 4'hB;
    #1;
    checks++; if (bus_if.a_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got %b expected 1", bus_if.a_gnt); end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus_if.a_rvalid !== 1'b0 || bus_if.b_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b%b expected 00", bus_if.a_rvalid, bus_if.b_rvalid); end
    checks++; if (bus_if.rdata !== 4'h0) begin errors++; $display("FAIL midrst_rdata got %h expected 0", bus_if.rdata); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_clear();
    test_clear_restart_ignored();
    test_clear_reset_abort();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
